// File: rtl/deserializer.sv
// Serial-to-parallel word receiver: frames start on a qualified sync bit, arrive MSB first,
// and complete into a registered output word with a valid/ready hand-off and sticky overrun.
module deserializer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sen,
    input  logic         sin,
    input  logic         sync,
    input  logic         ready,
    output logic [N-1:0] q,
    output logic         valid,
    output logic         busy,
    output logic         overrun
);

    localparam int CW = $clog2(N);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t         state, state_nx;
    logic [N-1:0]   sr, sr_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic [N-1:0]   word;
    logic           done;

    assign word = {sr[N-2:0], sin};
    assign busy = (state == SHIFT);

    always_comb begin
        state_nx = state;
        sr_nx    = sr;
        cnt_nx   = cnt;
        done     = 1'b0;
        if (sen) begin
            // A sync bit always (re)starts a frame, whatever the current state.
            if (sync) begin
                sr_nx    = {{(N-1){1'b0}}, sin};
                cnt_nx   = CW'(1);
                state_nx = SHIFT;
            end else if (state == SHIFT) begin
                if (cnt == CW'(N-1)) begin
                    done     = 1'b1;
                    sr_nx    = word;
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else begin
                    sr_nx  = word;
                    cnt_nx = cnt + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            sr    <= sr_nx;
            cnt   <= cnt_nx;
        end
    end

    // A completed word lands in q on the same edge as its last bit unless an unaccepted word blocks it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q       <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else if (done) begin
            if (!valid || ready) begin
                q     <= word;
                valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule
